alu_mul_share_ctrl: RTL and testbench

- Arbitrates NUM_REQ requesters onto one shared 64-bit multi-cycle integer multiplier (8 partial-product ticks per operation).
- Sequences the multiplier: start pulse, wait for completion, capture result, return it tagged to the winning requester.
- Sits between the ALU issue ports and the multiplier instance; owns the multiplier's start and clean lines.

---
 rtl/alu_mul_share_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_alu_mul_share_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_share_ctrl.sv
// alu_mul_share_ctrl: round-robin arbiter and sequencer that shares one
// multi-cycle integer multiplier between NUM_REQ ALU issue ports. One
// operation is outstanding at a time; the product is returned tagged with
// the index of the requester that issued it.
module alu_mul_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clean,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_numA,
  input  logic [NUM_REQ*DATA_W-1:0] req_numB,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_numC,
  input  logic                      resp_ready,
  output logic                      mul_start,
  output logic [DATA_W-1:0]         mul_numA,
  output logic [DATA_W-1:0]         mul_numB,
  output logic                      mul_clean,
  input  logic [DATA_W-1:0]         mul_numC,
  input  logic                      mul_done,
  output logic                      busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]     resp_id_q, resp_id_d;
  logic [DATA_W-1:0]   resp_numc_q, resp_numc_d;
  logic                mul_start_q, mul_start_d;
  logic [DATA_W-1:0]   mul_numa_q, mul_numa_d;
  logic [DATA_W-1:0]   mul_numb_q, mul_numb_d;
  logic                mul_clean_q, mul_clean_d;
  logic                busy_q, busy_d;

  logic                grant_found_s;
  logic [ID_W-1:0]     grant_idx_s;
  logic [DATA_W-1:0]   opa_s [NUM_REQ];
  logic [DATA_W-1:0]   opb_s [NUM_REQ];

  // Unpack the flat operand buses so the winner's slice is a plain array read.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign opa_s[g] = req_numA[g*DATA_W +: DATA_W];
    assign opb_s[g] = req_numB[g*DATA_W +: DATA_W];
  end

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    logic [ID_W:0] cand;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand          = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end else begin
        cand = cand;
      end
      if (!grant_found_s && req_valid[cand[ID_W-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand[ID_W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Next-state and output decode; clean overrides every state.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_numc_d  = resp_numc_q;
    mul_start_d  = 1'b0;
    mul_numa_d   = mul_numa_q;
    mul_numb_d   = mul_numb_q;
    mul_clean_d  = 1'b0;
    req_ready    = '0;
    if (clean) begin
      // Flush: abort, drop any pending result, keep fairness pointer.
      state_d      = S_IDLE;
      resp_valid_d = 1'b0;
      mul_clean_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_found_s && rst) begin
            req_ready   = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
            mul_numa_d  = opa_s[grant_idx_s];
            mul_numb_d  = opb_s[grant_idx_s];
            resp_id_d   = grant_idx_s;
            mul_start_d = 1'b1;
            state_d     = S_ISSUE;
            if (grant_idx_s == ID_W'(NUM_REQ-1)) begin
              rr_ptr_d = '0;
            end else begin
              rr_ptr_d = grant_idx_s + ID_W'(1);
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ISSUE: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (mul_done) begin
            resp_numc_d  = mul_numC;
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_d = 1'b0;
            state_d      = S_IDLE;
          end else begin
            state_d = S_RESP;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_numc_q  <= '0;
      mul_start_q  <= 1'b0;
      mul_numa_q   <= '0;
      mul_numb_q   <= '0;
      mul_clean_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_numc_q  <= resp_numc_d;
      mul_start_q  <= mul_start_d;
      mul_numa_q   <= mul_numa_d;
      mul_numb_q   <= mul_numb_d;
      mul_clean_q  <= mul_clean_d;
      busy_q       <= busy_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_numC  = resp_numc_q;
  assign mul_start  = mul_start_q;
  assign mul_numA   = mul_numa_q;
  assign mul_numB   = mul_numb_q;
  assign mul_clean  = mul_clean_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_mul_share_ctrl.sv
// Self-checking bench for alu_mul_share_ctrl. The bench plays the role of
// the 8-tick multiplier and keeps a behavioural round-robin model.
module tb_alu_mul_share_ctrl;
  localparam int NR = 4;
  localparam int DW = 64;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             clean;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_numA, req_numB;
  logic [NR-1:0]    req_ready;
  logic             resp_valid;
  logic [IW-1:0]    resp_id;
  logic [DW-1:0]    resp_numC;
  logic             resp_ready;
  logic             mul_start;
  logic [DW-1:0]    mul_numA, mul_numB;
  logic             mul_clean;
  logic [DW-1:0]    mul_numC;
  logic             mul_done;
  logic             busy;

  logic [DW-1:0] opA [NR];
  logic [DW-1:0] opB [NR];
  int vectors = 0;
  int miscompares = 0;
  int rr_m = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign req_numA[g*DW +: DW] = opA[g];
    assign req_numB[g*DW +: DW] = opB[g];
  end

  alu_mul_share_ctrl #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .clean(clean),
    .req_valid(req_valid), .req_numA(req_numA), .req_numB(req_numB),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_numC(resp_numC),
    .resp_ready(resp_ready),
    .mul_start(mul_start), .mul_numA(mul_numA), .mul_numB(mul_numB),
    .mul_clean(mul_clean), .mul_numC(mul_numC), .mul_done(mul_done),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Round-robin reference: first valid index scanning from rr_m upward, mod NR.
  function automatic int pick(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (rr_m + k) % NR;
      if (((v >> i) & NR'(1)) != '0) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    chk("rst_resp_numC", resp_numC, 64'd0);
    chk("rst_mul_start", 64'(mul_start), 64'd0);
    chk("rst_mul_numA", mul_numA, 64'd0);
    chk("rst_mul_numB", mul_numB, 64'd0);
    chk("rst_mul_clean", 64'(mul_clean), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
  endtask

  // Accept through completion; returns in the first cycle resp_valid should be high.
  task automatic run_to_resp(input logic [NR-1:0] v, output int w, output logic [DW-1:0] p);
    w = pick(v);
    p = opA[IW'(w)] * opB[IW'(w)];
    req_valid = v;
    @(negedge clk);
    chk("grant", 64'(req_ready), 64'd1 << w);
    chk("busy_idle", 64'(busy), 64'd0);
    tick();
    rr_m = (w + 1) % NR;
    req_valid = '0;
    mul_done = 1'b1;               // done in ISSUE must be ignored
    mul_numC = rand64();
    @(negedge clk);
    chk("mul_start", 64'(mul_start), 64'd1);
    chk("mul_numA", mul_numA, opA[IW'(w)]);
    chk("mul_numB", mul_numB, opB[IW'(w)]);
    chk("busy_run", 64'(busy), 64'd1);
    tick();
    mul_done = 1'b0;
    for (int k = 2; k <= 9; k++) begin
      req_valid = v;
      @(negedge clk);
      chk("no_restart", 64'(mul_start), 64'd0);
      chk("no_early_resp", 64'(resp_valid), 64'd0);
      chk("ready_when_busy", 64'(req_ready), 64'd0);
      tick();
    end
    req_valid = '0;
    mul_done = 1'b1;
    mul_numC = p;
    @(negedge clk);
    chk("resp_at_done", 64'(resp_valid), 64'd0);
    tick();
    mul_done = 1'b0;
    mul_numC = rand64();
  endtask

  task automatic finish_resp(input int w, input logic [DW-1:0] p, input int hold);
    for (int k = 0; k < hold; k++) begin
      req_valid = '1;
      @(negedge clk);
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_id", 64'(resp_id), 64'(w));
      chk("hold_numC", resp_numC, p);
      chk("hold_no_ready", 64'(req_ready), 64'd0);
      chk("hold_no_start", 64'(mul_start), 64'd0);
      tick();
    end
    req_valid = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("resp_valid", 64'(resp_valid), 64'd1);
    chk("resp_id", 64'(resp_id), 64'(w));
    chk("resp_numC", resp_numC, p);
    tick();
    resp_ready = 1'b0;
    @(negedge clk);
    chk("resp_cleared", 64'(resp_valid), 64'd0);
    chk("idle_after_resp", 64'(busy), 64'd0);
    tick();
  endtask

  task automatic run_op(input logic [NR-1:0] v, input int hold);
    int w;
    logic [DW-1:0] p;
    run_to_resp(v, w, p);
    finish_resp(w, p, hold);
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < NR; i++) begin
      opA[i] = rand64();
      opB[i] = rand64();
    end
  endtask

  initial begin
    int w;
    logic [DW-1:0] p;
    logic [NR-1:0] v;
    rst = 1'b0; clean = 1'b0; req_valid = '1; resp_ready = 1'b0;
    mul_done = 1'b0; mul_numC = '0;
    randomize_ops();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs();
    rst = 1'b1;
    req_valid = '0;
    rr_m = 0;
    tick();

    // Single request on requester 1: 3 * 5.
    opA[1] = 64'd3; opB[1] = 64'd5;
    run_op(4'b0010, 2);

    // Fairness with all requesters pending.
    randomize_ops();
    for (int n = 0; n < 5; n++) run_op(4'b1111, 0);
    run_op(4'b0100, 0);            // leaves pointer at 3
    run_op(4'b0101, 0);
    run_op(4'b0101, 0);

    // Backpressure with a truncated product.
    opA[3] = 64'hFFFF_FFFF_FFFF_FFFF; opB[3] = 64'd2;
    run_op(4'b1000, 20);

    // Random traffic.
    for (int n = 0; n < 6; n++) begin
      randomize_ops();
      v = NR'($urandom_range(1, 15));
      run_op(v, $urandom_range(0, 3));
    end

    // Flush four cycles after mul_start.
    v = 4'b1000;
    w = pick(v);
    req_valid = v;
    @(negedge clk);
    chk("flush_grant", 64'(req_ready), 64'd1 << w);
    tick();
    rr_m = (w + 1) % NR;
    req_valid = '0;
    @(negedge clk);
    chk("flush_start", 64'(mul_start), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    clean = 1'b1;
    @(negedge clk);
    chk("flush_no_early_clean", 64'(mul_clean), 64'd0);
    tick();
    clean = 1'b0;
    @(negedge clk);
    chk("flush_mul_clean", 64'(mul_clean), 64'd1);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_no_resp", 64'(resp_valid), 64'd0);
    tick();
    mul_done = 1'b1;
    mul_numC = rand64();
    @(negedge clk);
    chk("flush_clean_once", 64'(mul_clean), 64'd0);
    tick();
    mul_done = 1'b0;
    @(negedge clk);
    chk("late_done_ignored", 64'(resp_valid), 64'd0);
    chk("late_done_idle", 64'(busy), 64'd0);
    tick();

    // Clean in IDLE suppresses the grant.
    req_valid = '1;
    clean = 1'b1;
    @(negedge clk);
    chk("clean_no_grant", 64'(req_ready), 64'd0);
    tick();
    clean = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("clean_no_accept", 64'(busy), 64'd0);
    chk("clean_no_start", 64'(mul_start), 64'd0);
    tick();

    // Clean colliding with the response handshake.
    randomize_ops();
    run_to_resp(4'b1111, w, p);
    resp_ready = 1'b1;
    clean = 1'b1;
    @(negedge clk);
    chk("coll_valid_before", 64'(resp_valid), 64'd1);
    tick();
    clean = 1'b0;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("coll_dropped", 64'(resp_valid), 64'd0);
    chk("coll_idle", 64'(busy), 64'd0);
    chk("coll_mul_clean", 64'(mul_clean), 64'd1);
    tick();
    run_op(4'b1111, 1);            // pointer must be unaffected by the clean

    // Asynchronous reset while waiting on the multiplier.
    v = 4'b0010;
    w = pick(v);
    req_valid = v;
    tick();
    rr_m = (w + 1) % NR;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    req_valid = '1;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outs();
    tick();
    rst = 1'b1;
    req_valid = '0;
    rr_m = 0;
    run_op(4'b1111, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
